// File: rtl/bram_pkg.sv
// Shared BRAM-path definitions: word width and the reader/writer FSM state encodings.
package bram_pkg;

   localparam int BYTE_BITS = 8;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_TRIG,
      RD_WAIT
   } rd_state_t;

   typedef enum logic [2:0] {
      WR_IDLE,
      WR_SRC_TRIG,
      WR_SRC_WAIT,
      WR_ROOM_WAIT,
      WR_BRAM_TRIG,
      WR_BRAM_WAIT
   } wr_state_t;

endpackage

// File: rtl/bram_writer_fsm.sv
// Handshake sequencer for the BRAM writer: fetch one word from the producer, then commit it.
//
// state        | meaning
// WR_IDLE      | waiting for the producer to be ready
// WR_SRC_TRIG  | src_trigger asserted for one enabled edge
// WR_SRC_WAIT  | waiting for src_done; latch word when it arrives
// WR_ROOM_WAIT | word held until BRAM is idle and has a free slot
// WR_BRAM_TRIG | bram_trigger asserted for one enabled edge
// WR_BRAM_WAIT | waiting for bram_done; count the word when it arrives
module bram_writer_fsm
   import bram_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic clk_en,
   input  logic is_full,
   input  logic src_rdy,
   input  logic src_done,
   input  logic bram_rdy,
   input  logic bram_done,
   output logic src_trigger,
   output logic bram_trigger,
   output logic latch_data,
   output logic count_inc
);

   wr_state_t state;
   wr_state_t state_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= WR_IDLE;
      end else if (clk_en) begin
         state <= state_nxt;
      end
   end

   // Strobes are qualified with clk_en so the datapath needs no gating of its own.
   always_comb begin
      state_nxt    = state;
      src_trigger  = 1'b0;
      bram_trigger = 1'b0;
      latch_data   = 1'b0;
      count_inc    = 1'b0;
      case (state)
         WR_IDLE: begin
            if (src_rdy) state_nxt = WR_SRC_TRIG;
         end
         WR_SRC_TRIG: begin
            src_trigger = 1'b1;
            state_nxt   = WR_SRC_WAIT;
         end
         WR_SRC_WAIT: begin
            if (src_done) begin
               latch_data = clk_en;
               state_nxt  = WR_ROOM_WAIT;
            end
         end
         WR_ROOM_WAIT: begin
            if (bram_rdy && !is_full) state_nxt = WR_BRAM_TRIG;
         end
         WR_BRAM_TRIG: begin
            bram_trigger = 1'b1;
            state_nxt    = WR_BRAM_WAIT;
         end
         WR_BRAM_WAIT: begin
            if (bram_done) begin
               count_inc = clk_en;
               state_nxt = WR_IDLE;
            end
         end
         default: state_nxt = WR_IDLE;
      endcase
   end

endmodule

// File: rtl/bram_writer.sv
// BRAM write path: pulls words from a producer one at a time and commits them to the BRAM
// controller, holding the word locally and counting completed writes.
module bram_writer
   import bram_pkg::*;
#(
   parameter int DATA_BITS  = BYTE_BITS,
   parameter int COUNT_BITS = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clk_en,
   input  logic                  is_full,
   input  logic                  src_rdy,
   input  logic                  src_done,
   input  logic [DATA_BITS-1:0]  src_data,
   input  logic                  bram_rdy,
   input  logic                  bram_done,
   output logic                  src_trigger,
   output logic                  bram_trigger,
   output logic [DATA_BITS-1:0]  bram_data,
   output logic [COUNT_BITS-1:0] words_written
);

   logic latch_data;
   logic count_inc;

   bram_writer_fsm u_fsm (
      .clk          (clk),
      .reset        (reset),
      .clk_en       (clk_en),
      .is_full      (is_full),
      .src_rdy      (src_rdy),
      .src_done     (src_done),
      .bram_rdy     (bram_rdy),
      .bram_done    (bram_done),
      .src_trigger  (src_trigger),
      .bram_trigger (bram_trigger),
      .latch_data   (latch_data),
      .count_inc    (count_inc)
   );

   // Counter wraps silently; it is a status value, not a flow-control signal.
   always_ff @(posedge clk) begin
      if (reset) begin
         bram_data     <= '0;
         words_written <= '0;
      end else begin
         if (latch_data) bram_data     <= src_data;
         if (count_inc)  words_written <= words_written + COUNT_BITS'(1);
      end
   end

endmodule
